mod997_accum: RTL and testbench

MOD997_ACCUM -- requirements
Module: mod997_accum

---
 rtl/mod997_accum_if.sv | 28 ++
 rtl/mod997_accum.sv | 106 ++++++++++
 tb/tb_mod997_accum.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mod997_accum_if.sv
// Term/result handshake bundle for mod997_accum.
// master: term producer + result consumer; slave: the accumulator.
interface mod997_accum_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_residue;
  logic [4:0]   out_count;
  logic         out_ovf;
  logic         out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_residue,
    input  out_count, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_residue,
    output out_count, out_ovf, out_err
  );
endinterface

// File: rtl/mod997_accum.sv
// Accumulates partial residues mod MODULUS; ports: clk, rst_n, bus (slave).
// MOD997_RANGE_CHECK_EN: flag terms >= MODULUS in out_err, double reduce.
module mod997_accum #(
  parameter int MODULUS   = 997,
  parameter int W         = 10,
  parameter int MAX_TERMS = 17
) (
  input logic            clk,
  input logic            rst_n,
  mod997_accum_if.slave  bus
);

  typedef enum logic {ACC, DONE} state_t;

  localparam logic [W:0]   MOD_X  = (W+1)'(MODULUS);
  localparam logic [W-1:0] MOD_W  = W'(MODULUS);
  localparam logic [4:0]   LAST_C = 5'(MAX_TERMS - 1);

  state_t       state, state_d;
  logic [1:0]   rst_q;
  logic [W-1:0] acc;
  logic [4:0]   count;
  logic         ovf;
  logic         accept;
  logic         clr;
  logic         at_cap;
  logic [W:0]   sum;
  logic [W-1:0] sum1;
  logic [W-1:0] acc_n;

  // Release from reset only after two edges so the first accept is late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign bus.in_ready    = (state == ACC) && rst_q[1];
  assign bus.out_valid   = (state == DONE);
  assign bus.out_residue = acc;
  assign bus.out_count   = count;
  assign bus.out_ovf     = ovf;

  assign accept = bus.in_valid && bus.in_ready;
  assign clr    = (state == DONE) && bus.out_ready;
  assign at_cap = (count == LAST_C);

  // acc < MODULUS, so one subtract leaves a value below 2^W.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, bus.in_data};
    sum1 = (sum >= MOD_X) ? W'(sum - MOD_X) : sum[W-1:0];
`ifdef MOD997_RANGE_CHECK_EN
    acc_n = (sum1 >= MOD_W) ? (sum1 - MOD_W) : sum1;
`else
    acc_n = sum1;
`endif
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ACC: begin
        if (accept && (bus.in_last || at_cap)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_n;
      count <= count + 5'd1;
      ovf   <= !bus.in_last && at_cap;
    end
  end

`ifdef MOD997_RANGE_CHECK_EN
  logic err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err <= 1'b0;
    else if (clr)    err <= 1'b0;
    else if (accept) err <= err | ({1'b0, bus.in_data} >= MOD_X);
  end

  assign bus.out_err = err;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod997_accum.sv
// Randomized bench for mod997_accum against an arithmetic reference.
// Directed operands cover the boundary cases, then random operands.
module tb_mod997_accum;

  localparam int M    = 997;
  localparam int W    = 10;
  localparam int MAXT = 17;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   q[$];

  mod997_accum_if #(.W(W)) bus ();

  mod997_accum #(
    .MODULUS(M), .W(W), .MAX_TERMS(MAXT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Drives q as one operand, then checks the result and the release.
  task automatic run_op(input bit use_last, input int hold);
    int er, ec, eo, ee, n, idx, guard;
    er = 0; ec = 0; eo = 0; ee = 0; n = 0;
    for (int i = 0; i < q.size(); i++) begin
      er = (er + q[i]) % M;
      ec++;
      if (q[i] >= M) ee = 1;
      n++;
      if (use_last && i == q.size() - 1) break;
      if (ec == MAXT) begin
        eo = 1;
        break;
      end
    end
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'(q[idx]);
        bus.in_last  = use_last && (idx == q.size() - 1);
        if (bus.in_ready) idx++;
      end
    end
    if (idx < n) chk("accept_timeout", idx, n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("latency", int'(bus.out_valid), 1);
    chk("residue", int'(bus.out_residue), er);
    chk("count", int'(bus.out_count), ec);
    chk("ovf", int'(bus.out_ovf), eo);
    chk("err", int'(bus.out_err), ee);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom_range(0, M - 1));
      @(negedge clk);
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_ready", int'(bus.in_ready), 0);
      chk("hold_residue", int'(bus.out_residue), er);
      chk("hold_count", int'(bus.out_count), ec);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(7);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("rel_valid", int'(bus.out_valid), 0);
    chk("rel_ready", int'(bus.in_ready), 1);
    chk("rel_count", int'(bus.out_count), 0);
    chk("rel_residue", int'(bus.out_residue), 0);
    chk("rel_ovf", int'(bus.out_ovf), 0);
  endtask

  initial begin
    int len;
    bit ul;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_residue", int'(bus.out_residue), 0);
    chk("rst_count", int'(bus.out_count), 0);
    chk("rst_ovf", int'(bus.out_ovf), 0);
    chk("rst_err", int'(bus.out_err), 0);
    rst_n = 1'b1;
    #1 chk("rst_sync_ready", int'(bus.in_ready), 0);

    q = '{500, 500, 500};
    run_op(1'b1, 0);
    q = '{996};
    run_op(1'b1, 0);
    q = '{1};
    run_op(1'b1, 5);
    q = {};
    for (int i = 0; i < MAXT; i++) q.push_back(1);
    run_op(1'b0, 1);
`ifdef MOD997_RANGE_CHECK_EN
    q = '{1000};
    run_op(1'b1, 0);
`endif

    // Abort an operand with reset after two accepted terms.
    q = '{5, 6, 7};
    len = 0;
    while (len < 2) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = W'(q[len]);
      bus.in_last  = 1'b0;
      if (bus.in_ready) len++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(bus.out_valid), 0);
    chk("abort_residue", int'(bus.out_residue), 0);
    chk("abort_count", int'(bus.out_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort_sync_ready", int'(bus.in_ready), 0);
    q = '{10, 20};
    run_op(1'b1, 0);

    for (int k = 0; k < 40; k++) begin
      ul  = ($urandom_range(0, 3) != 0);
      len = ul ? $urandom_range(1, 20) : $urandom_range(MAXT, 20);
      q = {};
      for (int i = 0; i < len; i++) begin
`ifdef MOD997_RANGE_CHECK_EN
        if ($urandom_range(0, 7) == 0) q.push_back($urandom_range(M, 1023));
        else q.push_back($urandom_range(0, M - 1));
`else
        q.push_back($urandom_range(0, M - 1));
`endif
      end
      run_op(ul, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
